sequential_divider: RTL and testbench

- Iterative unsigned N-bit divider; the inverse operation of the accumulator-based multiplier path in the same datapath family.
- Accepts a dividend/divisor pair through a valid/ready handshake and produces one quotient bit per cycle using a radix-2 restoring algorithm.
- Returns quotient, remainder and a divide-by-zero flag through a second valid/ready handshake.
- Sits beside the accumulator/multiplier in the arithmetic unit. One operation is in flight at a time.

---
 rtl/sequential_divider.sv | 92 +++++++++
 tb/tb_sequential_divider.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// Iterative unsigned N-bit restoring divider: one quotient bit per cycle,
// valid/ready handshakes on both the operand and the result side.
module sequential_divider #(
  parameter int N = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [N-1:0]     d_reg;
  logic [N-1:0]     q_reg;
  // The partial remainder is always below the divisor after a step, so N bits hold it.
  logic [N-1:0]     r_reg;

  logic [N:0]       r_shift;
  logic [N:0]       trial;
  logic [N-1:0]     r_next;
  logic [N-1:0]     q_next;

  always_comb begin
    r_shift = {r_reg, q_reg[N-1]};
    trial   = r_shift - {1'b0, d_reg};
    r_next  = trial[N] ? r_shift[N-1:0] : trial[N-1:0];
    q_next  = {q_reg[N-2:0], ~trial[N]};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
              state     <= DONE;
            end else begin
              d_reg <= divisor;
              q_reg <= dividend;
              r_reg <= '0;
              count <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            quotient  <= q_next;
            remainder <= r_next;
            div_zero  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: stimulus pushes expected results
// computed with plain / and %, a monitor pops them on each result handshake.
module tb_sequential_divider;

  localparam int N = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  sequential_divider #(.N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Waits for in_ready, presents one operation, returns just after the acceptance edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid, checking in_ready stays low meanwhile.
  task automatic wait_result(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      if (in_ready) check("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clock); #1;
      edges++;
    end
    if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: one comparison set per completed result handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("quotient", 32'(quotient), 32'(e.q));
          check("remainder", 32'(remainder), 32'(e.r));
          check("div_zero", 32'(div_zero), 32'(e.z));
          if (!e.z) begin
            check("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
            check("rem_lt_div", 32'(remainder < e.b), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    int edges;
    logic [N-1:0] hq, hr;
    logic [N-1:0] ra, rb;

    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    issue(16'd100, 16'd7);
    wait_result(edges);
    check("latency_normal", 32'(edges), 32'd16);
    @(posedge clock); #1;

    issue(16'hFFFF, 16'd1);
    wait_result(edges);
    issue(16'd5, 16'd9);
    wait_result(edges);
    issue(16'hFFFF, 16'hFFFF);
    wait_result(edges);

    issue(16'd1234, 16'd0);
    check("latency_div0", 32'(out_valid), 32'd1);
    issue(16'd40, 16'd8);
    wait_result(edges);
    @(posedge clock); #1;

    // Backpressure: result held, new operands refused.
    out_ready = 1'b0;
    issue(16'd100, 16'd7);
    wait_result(edges);
    hq = quotient;
    hr = remainder;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      dividend = 16'(i * 37 + 3);
      divisor  = 16'(i + 2);
      @(posedge clock); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", 32'(quotient), 32'(hq));
      check("bp_remainder", 32'(remainder), 32'(hr));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // Abort mid-run at iteration 7.
    issue(16'd1000, 16'd3);
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    sb.delete();
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_div_zero", 32'(div_zero), 32'd0);
    issue(16'd1000, 16'd3);
    wait_result(edges);
    @(posedge clock); #1;

    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 16'($urandom_range(1, 15));
        2: rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      issue(ra, rb);
      wait_result(edges);
    end

    edges = 0;
    while (sb.size() != 0 && edges < 100) begin
      @(posedge clock); #1;
      edges++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
